// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field layout,
// squash FSM encoding and small decode helpers.
package decode_stage_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } squash_state_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [25:0] jidx;
  } fields_t;

  function automatic fields_t split_word(input logic [31:0] w);
    fields_t f;
    f.op    = w[31:26];
    f.rs    = w[25:21];
    f.rt    = w[20:16];
    f.rd    = w[15:11];
    f.imm   = w[15:0];
    f.funct = w[5:0];
    f.jidx  = w[25:0];
    return f;
  endfunction

  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one write port, r0 hardwired to zero, synchronous clear on reset.
module reg_file
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREG];
  logic          wr_ok;

  // Reset dominates the write port, so no write (or bypass) happens while reset is high.
  assign wr_ok = we && !reset && (waddr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == '0)                    rdata_a = '0;
    else if (wr_ok && waddr == raddr_a)   rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == '0)                    rdata_b = '0;
    else if (wr_ok && waddr == raddr_b)   rdata_b = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, BEQ/BNE/J resolution with a one-word squash,
// and the ID/EX pipeline latch.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_RUN  | normal decode; branches resolve and may redirect fetch
//   ST_KILL | word in decode is wrong-path; decoded as NOP, no redirect
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instruction,
  input  logic [DW-1:0] Next_PC,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] brPC,
  output logic          sel_mux,
  output logic          ex_valid,
  output logic [5:0]    ex_opcode,
  output logic [5:0]    ex_funct,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_rd,
  output logic [DW-1:0] ex_pc
);

  squash_state_e state, state_nxt;
  logic          squash;
  logic          taken;
  logic [DW-1:0] br_target;
  logic [31:0]   word;
  fields_t       f;
  logic [DW-1:0] rs_data, rt_data;

  // A killed word is replaced by NOP so nothing from it reaches execute or fetch.
  assign word = squash ? NOP_WORD : instruction;
  assign f    = split_word(word);

  reg_file u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (f.rs),
    .raddr_b (f.rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  always_comb begin
    taken     = 1'b0;
    br_target = '0;
    if (!squash && !reset) begin
      unique case (f.op)
        OP_BEQ: begin
          taken     = (rs_data == rt_data);
          br_target = Next_PC + sign_ext(f.imm);
        end
        OP_BNE: begin
          taken     = (rs_data != rt_data);
          br_target = Next_PC + sign_ext(f.imm);
        end
        OP_J: begin
          taken     = 1'b1;
          br_target = {Next_PC[DW-1:26], f.jidx};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:  if (taken) state_nxt = ST_KILL;
      ST_KILL: state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    squash  = (state == ST_KILL);
    sel_mux = taken;
    brPC    = taken ? br_target : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= '0;
      ex_funct   <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_pc      <= '0;
    end else begin
      ex_valid   <= !squash;
      ex_opcode  <= f.op;
      ex_funct   <= f.funct;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= sign_ext(f.imm);
      ex_rt      <= f.rt;
      ex_rd      <= f.rd;
      ex_pc      <= Next_PC;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table plus random
// stimulus, both compared against a behavioural pipeline model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, Next_PC, wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] brPC;
  logic        sel_mux, ex_valid;
  logic [5:0]  ex_opcode, ex_funct;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [4:0]  ex_rt, ex_rd;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .instruction(instruction), .Next_PC(Next_PC),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .brPC(brPC), .sel_mux(sel_mux), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_pc(ex_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register array plus a "next word is dead" flag.
  logic [31:0] m_regs [32];
  bit          m_dead;

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit rst, input bit we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && !rst && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, 6'h20};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Apply one cycle; check the redirect before the edge and the ID/EX latch after it.
  task automatic step(input bit rst, input logic [31:0] ins, input logic [31:0] npc,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] w, a, b, tgt, e_imm;
    bit          tk, ev;
    @(negedge clk);
    reset = rst; instruction = ins; Next_PC = npc;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    w  = m_dead ? 32'h0 : ins;
    a  = m_read(w[25:21], rst, we, wa, wd);
    b  = m_read(w[20:16], rst, we, wa, wd);
    tk = 0; tgt = 0;
    e_imm = 32'($signed(w[15:0]));
    if (!rst && !m_dead) begin
      if (w[31:26] == 6'h04 && a == b) begin tk = 1; tgt = npc + e_imm; end
      if (w[31:26] == 6'h05 && a != b) begin tk = 1; tgt = npc + e_imm; end
      if (w[31:26] == 6'h02) begin tk = 1; tgt = {npc[31:26], w[25:0]}; end
    end
    chk("sel_mux", 32'(sel_mux), 32'(tk));
    chk("brPC", brPC, tgt);
    ev = !rst && !m_dead;
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(ev));
    if (rst) begin
      chk("rst_ex_pc", ex_pc, 0);
      chk("rst_ex_rs", ex_rs_data, 0);
      chk("rst_ex_op", 32'(ex_opcode), 0);
    end else if (ev) begin
      chk("ex_opcode", 32'(ex_opcode), 32'(ins[31:26]));
      chk("ex_funct", 32'(ex_funct), 32'(ins[5:0]));
      chk("ex_rs_data", ex_rs_data, a);
      chk("ex_rt_data", ex_rt_data, b);
      chk("ex_imm", ex_imm, e_imm);
      chk("ex_rt", 32'(ex_rt), 32'(ins[20:16]));
      chk("ex_rd", 32'(ex_rd), 32'(ins[15:11]));
      chk("ex_pc", ex_pc, npc);
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_dead = 0;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      m_dead = m_dead ? 0 : tk;
    end
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] ins, npc;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          e_sel;
    logic [31:0] e_brpc;
    bit          e_valid;
    logic [31:0] e_rs, e_rt;
  } vec_t;

  vec_t vq[$];
  bit   s_sel;
  logic [31:0] s_brpc;

  initial begin
    reset = 1; instruction = 0; Next_PC = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_dead = 0;

    //            rst ins                            npc            we wa wd            sel brpc          val rs         rt
    vq.push_back('{1, itype(6'h04,1,2,16'h0004),     32'd10,        1, 3, 32'h5,        0, 32'h0,         0,  32'h0,     32'h0});
    vq.push_back('{1, rtype(3,3,4),                  32'd11,        1, 3, 32'h5,        0, 32'h0,         0,  32'h0,     32'h0});
    vq.push_back('{0, rtype(3,4,6),                  32'd12,        0, 0, 32'h0,        0, 32'h0,         1,  32'h0,     32'h0});
    vq.push_back('{0, rtype(5,0,6),                  32'd13,        1, 5, 32'hDEAD,     0, 32'h0,         1,  32'hDEAD,  32'h0});
    vq.push_back('{0, rtype(0,5,6),                  32'd14,        1, 0, 32'h7,        0, 32'h0,         1,  32'h0,     32'hDEAD});
    vq.push_back('{0, rtype(5,0,6),                  32'd15,        1, 1, 32'd9,        0, 32'h0,         1,  32'hDEAD,  32'h0});
    vq.push_back('{0, rtype(1,2,6),                  32'd16,        1, 2, 32'd9,        0, 32'h0,         1,  32'd9,     32'd9});
    vq.push_back('{0, itype(6'h04,1,2,16'hFFFD),     32'd20,        0, 0, 32'h0,        1, 32'd17,        1,  32'd9,     32'd9});
    vq.push_back('{0, rtype(1,2,7),                  32'd21,        0, 0, 32'h0,        0, 32'h0,         0,  32'h0,     32'h0});
    vq.push_back('{0, rtype(1,5,7),                  32'd18,        0, 0, 32'h0,        0, 32'h0,         1,  32'd9,     32'hDEAD});
    vq.push_back('{0, itype(6'h05,1,2,16'h0005),     32'd30,        0, 0, 32'h0,        0, 32'h0,         1,  32'd9,     32'd9});
    vq.push_back('{0, rtype(2,1,7),                  32'd31,        0, 0, 32'h0,        0, 32'h0,         1,  32'd9,     32'd9});
    vq.push_back('{0, itype(6'h04,1,2,16'h0004),     32'd40,        0, 0, 32'h0,        1, 32'd44,        1,  32'd9,     32'd9});
    vq.push_back('{0, jtype(26'h100),                32'd41,        0, 0, 32'h0,        0, 32'h0,         0,  32'h0,     32'h0});
    vq.push_back('{0, rtype(5,1,7),                  32'd45,        0, 0, 32'h0,        0, 32'h0,         1,  32'hDEAD,  32'd9});
    vq.push_back('{0, jtype(26'h40),                 32'hFC00_0010, 0, 0, 32'h0,        1, 32'hFC00_0040, 1,  32'h0,     32'h0});
    vq.push_back('{1, itype(6'h04,1,2,16'h0001),     32'd50,        1, 4, 32'h1,        0, 32'h0,         0,  32'h0,     32'h0});
    vq.push_back('{1, jtype(26'h77),                 32'd51,        0, 0, 32'h0,        0, 32'h0,         0,  32'h0,     32'h0});
    vq.push_back('{0, rtype(1,2,3),                  32'd60,        0, 0, 32'h0,        0, 32'h0,         1,  32'h0,     32'h0});
    vq.push_back('{0, itype(6'h04,1,2,16'h0002),     32'd100,       0, 0, 32'h0,        1, 32'd102,       1,  32'h0,     32'h0});
    vq.push_back('{0, itype(6'h05,1,2,16'h0002),     32'd101,       0, 0, 32'h0,        0, 32'h0,         0,  32'h0,     32'h0});
    vq.push_back('{0, rtype(0,0,0),                  32'd102,       0, 0, 32'h0,        0, 32'h0,         1,  32'h0,     32'h0});

    foreach (vq[i]) begin
      fork
        begin
          @(negedge clk); #2;
          s_sel  = sel_mux;
          s_brpc = brPC;
        end
        step(vq[i].rst, vq[i].ins, vq[i].npc, vq[i].we, vq[i].wa, vq[i].wd);
      join
      chk($sformatf("vec%0d_sel", i), 32'(s_sel), 32'(vq[i].e_sel));
      chk($sformatf("vec%0d_brpc", i), s_brpc, vq[i].e_brpc);
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vq[i].e_valid));
      if (vq[i].e_valid) begin
        chk($sformatf("vec%0d_rs", i), ex_rs_data, vq[i].e_rs);
        chk($sformatf("vec%0d_rt", i), ex_rt_data, vq[i].e_rt);
      end
    end

    // Random traffic; small register indices and a narrow data set make branches hit often.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins, wd;
      logic [5:0]  op;
      int          k;
      k = $urandom_range(0, 9);
      op = (k < 3) ? 6'h04 : (k < 5) ? 6'h05 : (k < 6) ? 6'h02 : (k < 8) ? 6'h00 : 6'($urandom);
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      wd  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      step($urandom_range(0, 49) == 0, ins, $urandom, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
